// File: rtl/clkmon_pkg.sv
// clkmon_pkg: shared constants for the clock frequency monitor family.
// Holds the FSM state encoding and the default widths and stall limit.
package clkmon_pkg;

    localparam int CLKMON_CW          = 16;
    localparam int CLKMON_WW          = 16;
    localparam int CLKMON_STALL_LIMIT = 1024;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/clkmon_sync_edge.sv
// clkmon_sync_edge: 3-flop synchronizer with rising-edge pulse output.
// Ports: clk, resetb (async, active-low), async_in (foreign clock), rise.
module clkmon_sync_edge (
    input  logic clk,
    input  logic resetb,
    input  logic async_in,
    output logic rise
);

    logic [2:0] sync;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], async_in};
        end
    end

    // sync[0] is the metastability catcher and is never observed directly
    assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/clock_freq_monitor.sv
// clock_freq_monitor: counts mon_clk rising edges over a window of clk
// cycles and flags the result against low/high limits.
// Ports: clk, resetb, enable, mon_clk, start, window, lo_limit, hi_limit
//   in; busy, valid, count, too_slow, too_fast, overflow, stalled out.
// Optional: define CLKMON_STALL_DETECT_EN to enable the stall detector.
module clock_freq_monitor
    import clkmon_pkg::*;
#(
    parameter int CW = CLKMON_CW,
    parameter int WW = CLKMON_WW
`ifdef CLKMON_STALL_DETECT_EN
    ,
    parameter int STALL_LIMIT = CLKMON_STALL_LIMIT
`endif
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          enable,
    input  logic          mon_clk,
    input  logic          start,
    input  logic [WW-1:0] window,
    input  logic [CW-1:0] lo_limit,
    input  logic [CW-1:0] hi_limit,
    output logic          busy,
    output logic          valid,
    output logic [CW-1:0] count,
    output logic          too_slow,
    output logic          too_fast,
    output logic          overflow,
    output logic          stalled
);

    logic          rise;
    logic [1:0]    state;
    logic [WW-1:0] timer;
    logic [WW-1:0] timer_ld;
    logic [CW-1:0] edge_cnt;
    logic [CW-1:0] cnt_nxt;
    logic          cnt_full;
    logic          accept;
    logic          counting;

    clkmon_sync_edge u_sync (
        .clk      (clk),
        .resetb   (resetb),
        .async_in (mon_clk),
        .rise     (rise)
    );

    assign cnt_full = &edge_cnt;
    assign cnt_nxt  = (rise && !cnt_full) ? edge_cnt + 1'b1 : edge_cnt;
    // a zero window behaves as a one-cycle window
    assign timer_ld = (window == '0) ? '0 : window - 1'b1;
    assign counting = (state == ST_COUNT);
    assign accept   = start && enable && !counting;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state    <= ST_IDLE;
            timer    <= '0;
            edge_cnt <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            count    <= '0;
            too_slow <= 1'b0;
            too_fast <= 1'b0;
            overflow <= 1'b0;
        end else if (!enable) begin
            // results are kept; only the in-flight window is dropped
            state <= ST_IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            unique case (1'b1)
                accept: begin
                    state    <= ST_COUNT;
                    timer    <= timer_ld;
                    edge_cnt <= '0;
                    overflow <= 1'b0;
                    valid    <= 1'b0;
                    busy     <= 1'b1;
                end
                counting: begin
                    edge_cnt <= cnt_nxt;
                    timer    <= timer - 1'b1;
                    if (rise && cnt_full) begin
                        overflow <= 1'b1;
                    end
                    // the final cycle's edge is folded into the result
                    if (timer == '0) begin
                        state    <= ST_DONE;
                        count    <= cnt_nxt;
                        too_slow <= (cnt_nxt < lo_limit);
                        too_fast <= (cnt_nxt > hi_limit);
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CLKMON_STALL_DETECT_EN
    logic [WW-1:0] stall_cnt;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            stall_cnt <= '0;
        end else if (!enable || rise) begin
            stall_cnt <= '0;
        end else if (!(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign stalled = (stall_cnt >= WW'(STALL_LIMIT));
`else
    assign stalled = 1'b0;
`endif

endmodule

// File: tb/tb_clock_freq_monitor.sv
// tb_clock_freq_monitor: scoreboard bench for clock_freq_monitor.
// Drives a 100 MHz clk and a programmable mon_clk; checks results.
module tb_clock_freq_monitor;

    typedef struct {
        string tag;
        int    cnt;
        int    tol;
        bit    slow;
        bit    fast;
        bit    ovf;
        int    lat;
    } exp_t;

    exp_t sb[$];

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        enable = 1'b0;
    logic        mon_clk = 1'b0;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic [15:0] window = '0;
    logic [15:0] lo_limit = '0;
    logic [15:0] hi_limit = '0;
    logic [3:0]  lo4 = '0;
    logic [3:0]  hi4 = '0;

    logic        busy, valid, too_slow, too_fast, overflow, stalled;
    logic [15:0] count;
    logic        busy4, valid4, slow4, fast4, ovf4, stalled4;
    logic [3:0]  count4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mon_half = 0;

    clock_freq_monitor #(
        .CW (16),
        .WW (16)
`ifdef CLKMON_STALL_DETECT_EN
        ,
        .STALL_LIMIT (8)
`endif
    ) dut (
        .clk      (clk),
        .resetb   (resetb),
        .enable   (enable),
        .mon_clk  (mon_clk),
        .start    (start),
        .window   (window),
        .lo_limit (lo_limit),
        .hi_limit (hi_limit),
        .busy     (busy),
        .valid    (valid),
        .count    (count),
        .too_slow (too_slow),
        .too_fast (too_fast),
        .overflow (overflow),
        .stalled  (stalled)
    );

    clock_freq_monitor #(
        .CW (4),
        .WW (16)
    ) dut4 (
        .clk      (clk),
        .resetb   (resetb),
        .enable   (enable),
        .mon_clk  (mon_clk),
        .start    (start4),
        .window   (window),
        .lo_limit (lo4),
        .hi_limit (hi4),
        .busy     (busy4),
        .valid    (valid4),
        .count    (count4),
        .too_slow (slow4),
        .too_fast (fast4),
        .overflow (ovf4),
        .stalled  (stalled4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // mon_clk edges land on times = 1 or 6 mod 10, never on a clk edge
    always begin
        if (mon_half == 0) begin
            mon_clk = 1'b0;
            @(negedge clk);
            #1;
        end else begin
            #(mon_half) mon_clk = ~mon_clk;
        end
    end

    task automatic chk(input string tag, input longint got,
                       input longint exp, input longint tol = 0);
        longint d;
        checks++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
        end
    endtask

    task automatic measure(input string tag, input bit sel, input int w,
                           input int lo, input int hi, input int ecnt,
                           input int tol, input bit eslow, input bit efast,
                           input bit eovf, input int again = -1);
        exp_t e;
        exp_t g;
        int   s0;
        int   n;
        e.tag  = tag;
        e.cnt  = ecnt;
        e.tol  = tol;
        e.slow = eslow;
        e.fast = efast;
        e.ovf  = eovf;
        e.lat  = (w == 0) ? 1 : w;
        sb.push_back(e);
        @(negedge clk);
        window = w[15:0];
        if (sel) begin
            lo4 = lo[3:0];
            hi4 = hi[3:0];
            start4 = 1'b1;
        end else begin
            lo_limit = lo[15:0];
            hi_limit = hi[15:0];
            start = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        start4 = 1'b0;
        s0 = cyc;
        chk({tag, ":busy"}, sel ? busy4 : busy, 1);
        chk({tag, ":valid_clr"}, sel ? valid4 : valid, 0);
        n = 0;
        while (!(sel ? valid4 : valid) && n < w + 20) begin
            start = (n == again);
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        g = sb.pop_front();
        chk({g.tag, ":lat"}, cyc - s0, g.lat);
        chk({g.tag, ":count"}, sel ? count4 : count, g.cnt, g.tol);
        chk({g.tag, ":slow"}, sel ? slow4 : too_slow, g.slow);
        chk({g.tag, ":fast"}, sel ? fast4 : too_fast, g.fast);
        chk({g.tag, ":ovf"}, sel ? ovf4 : overflow, g.ovf);
        chk({g.tag, ":busy_end"}, sel ? busy4 : busy, 0);
    endtask

    initial begin
        #1;
        chk("rst:busy", busy, 0);
        chk("rst:valid", valid, 0);
        chk("rst:count", count, 0);
        chk("rst:slow", too_slow, 0);
        chk("rst:fast", too_fast, 0);
        chk("rst:ovf", overflow, 0);
        chk("rst:stalled", stalled, 0);
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        enable = 1'b1;

        // saturation on the narrow instance: 40 edges clip at 15
        mon_half = 25;
        repeat (10) @(posedge clk);
        measure("cw4", 1'b1, 200, 1, 10, 15, 0, 1'b0, 1'b1, 1'b1);

        mon_half = 50;
        repeat (10) @(posedge clk);
        measure("f10", 1'b0, 1000, 95, 105, 100, 1, 1'b0, 1'b0, 1'b0);

        // drop enable mid-window: results stay, status clears
        @(negedge clk);
        window = 16'd1000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("endrop:busy", busy, 0);
        chk("endrop:valid", valid, 0);
        chk("endrop:count", count, 100, 1);
        @(negedge clk);
        enable = 1'b1;

        // start with enable low must be ignored
        @(negedge clk);
        enable = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("en_lo_start:busy", busy, 0);
        @(negedge clk);
        enable = 1'b1;

        mon_half = 0;
        repeat (20) @(posedge clk);
        measure("hold_lo", 1'b0, 16, 1, 105, 0, 0, 1'b1, 1'b0, 1'b0);
`ifdef CLKMON_STALL_DETECT_EN
        chk("stall:set", stalled, 1);
        mon_half = 50;
        begin
            int n;
            n = 0;
            while (!mon_clk && n < 20) begin
                @(posedge clk);
                n++;
            end
            n = 0;
            while (stalled && n < 4) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("stall:clr", stalled, 0);
        mon_half = 0;
        repeat (10) @(posedge clk);
`else
        chk("stall:off", stalled, 0);
`endif
        measure("win0", 1'b0, 0, 1, 105, 0, 0, 1'b1, 1'b0, 1'b0);
        measure("restart", 1'b0, 16, 1, 105, 0, 0, 1'b1, 1'b0, 1'b0, 5);
        // inverted limits: both flags may set together
        measure("inv_lim", 1'b0, 4, 3, 0, 0, 0, 1'b1, 1'b0, 1'b0);

        mon_half = 100;
        repeat (10) @(posedge clk);
        measure("f5", 1'b0, 1000, 95, 105, 50, 1, 1'b1, 1'b0, 1'b0);
        mon_half = 50;
        repeat (10) @(posedge clk);
        measure("inv2", 1'b0, 1000, 150, 20, 100, 1, 1'b1, 1'b1, 1'b0);

        // async reset mid-window clears everything at once
        @(negedge clk);
        window = 16'd1000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        resetb = 1'b0;
        #1;
        chk("rstmid:busy", busy, 0);
        chk("rstmid:valid", valid, 0);
        chk("rstmid:count", count, 0);
        chk("rstmid:slow", too_slow, 0);
        chk("rstmid:fast", too_fast, 0);
        chk("rstmid:ovf4", ovf4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
